eeprom_slave: RTL

EEPROM_SLAVE -- requirements
Module: eeprom_slave

---
 rtl/eeprom_slave_pkg.sv | 19 +
 rtl/eeprom_bus_sync.sv | 39 +++
 rtl/eeprom_slave.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/eeprom_slave_pkg.sv
// Shared definitions for the I2C EEPROM slave: state encoding and memory geometry.
package eeprom_slave_pkg;

  localparam int MEM_DEPTH = 2048;
  localparam int ADDR_W    = 11;

  typedef enum logic [8:0] {
    IDLE      = 9'b000000001,
    CTRL      = 9'b000000010,
    ACK_CTRL  = 9'b000000100,
    WADDR     = 9'b000001000,
    ACK_WADDR = 9'b000010000,
    WDATA     = 9'b000100000,
    ACK_WDATA = 9'b001000000,
    RDATA     = 9'b010000000,
    MACK      = 9'b100000000
  } state_e;

endpackage

// File: rtl/eeprom_bus_sync.sv
// Synchronizes SCL/SDA into the CLK domain and produces one-cycle edge, START and STOP strobes.
module eeprom_bus_sync (
  input  logic CLK,
  input  logic RESET,
  input  logic SCL,
  input  logic sda_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic sda_s,
  output logic start_det,
  output logic stop_det
);

  // Bit 0 is the metastability stage, bit 1 the synchronized value, bit 2 its previous value.
  logic [2:0] scl_q, scl_d;
  logic [2:0] sda_q, sda_d;

  always_comb begin
    scl_d = {scl_q[1:0], SCL};
    sda_d = {sda_q[1:0], sda_in};
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      scl_q <= 3'b111;
      sda_q <= 3'b111;
    end else begin
      scl_q <= scl_d;
      sda_q <= sda_d;
    end
  end

  assign sda_s     = sda_q[1];
  assign scl_rise  = scl_q[1] & ~scl_q[2];
  assign scl_fall  = ~scl_q[1] & scl_q[2];
  assign start_det = scl_q[1] & scl_q[2] & sda_q[2] & ~sda_q[1];
  assign stop_det  = scl_q[1] & scl_q[2] & ~sda_q[2] & sda_q[1];

endmodule

// File: rtl/eeprom_slave.sv
// 2 KiB I2C EEPROM slave model: byte/page write, current/random/sequential read.
module eeprom_slave
  import eeprom_slave_pkg::*;
#(
  parameter logic [3:0] DEV_CODE  = 4'b1010,
  parameter int         PAGE_BITS = 4
) (
  input  logic CLK,
  input  logic RESET,
  input  logic SCL,
  inout  wire  SDA,
  output logic BUSY,
  output logic WR_PULSE
);

  logic scl_rise, scl_fall, sda_s, start_det, stop_det;

  state_e              state_q, state_d;
  logic [3:0]          bit_cnt_q, bit_cnt_d;
  logic [7:0]          shift_q, shift_d;
  logic [7:0]          rdata_q, rdata_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic                rw_q, rw_d;
  logic                sda_oe_q, sda_oe_d;
  logic                busy_q, busy_d;
  logic                wr_pulse_q, wr_pulse_d;
  logic                mem_we;
  logic [7:0]          rd_byte;
  logic [7:0]          mem_q [MEM_DEPTH];

  eeprom_bus_sync u_sync (
    .CLK       (CLK),
    .RESET     (RESET),
    .SCL       (SCL),
    .sda_in    (SDA),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .sda_s     (sda_s),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  assign rd_byte = mem_q[ptr_q];

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    rdata_d    = rdata_q;
    ptr_d      = ptr_q;
    rw_d       = rw_q;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy_q;
    wr_pulse_d = 1'b0;
    mem_we     = 1'b0;

    if (start_det) begin
      state_d   = CTRL;
      bit_cnt_d = '0;
      shift_d   = '0;
      sda_oe_d  = 1'b0;
    end else if (stop_det) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else begin
      if (scl_rise && (state_q inside {CTRL, WADDR, WDATA}) && (bit_cnt_q != 4'd8)) begin
        shift_d   = {shift_q[6:0], sda_s};
        bit_cnt_d = bit_cnt_q + 4'd1;
      end

      case (state_q)
        IDLE: ;
        CTRL: begin
          if (scl_fall && (bit_cnt_q == 4'd8)) begin
            bit_cnt_d = '0;
            if (shift_q[7:4] == DEV_CODE) begin
              state_d                = ACK_CTRL;
              sda_oe_d               = 1'b1;
              busy_d                 = 1'b1;
              ptr_d[ADDR_W-1:8]      = shift_q[3:1];
              rw_d                   = shift_q[0];
            end else begin
              state_d = IDLE;
              busy_d  = 1'b0;
            end
          end
        end
        ACK_CTRL: begin
          if (scl_fall) begin
            bit_cnt_d = '0;
            if (rw_q) begin
              state_d  = RDATA;
              rdata_d  = rd_byte;
              sda_oe_d = ~rd_byte[7];
            end else begin
              state_d  = WADDR;
              sda_oe_d = 1'b0;
            end
          end
        end
        WADDR: begin
          if (scl_fall && (bit_cnt_q == 4'd8)) begin
            ptr_d[7:0] = shift_q;
            state_d    = ACK_WADDR;
            sda_oe_d   = 1'b1;
            bit_cnt_d  = '0;
          end
        end
        ACK_WADDR: begin
          if (scl_fall) begin
            state_d  = WDATA;
            sda_oe_d = 1'b0;
          end
        end
        WDATA: begin
          // Only a complete byte reaches memory; the page offset wraps, the page number is held.
          if (scl_fall && (bit_cnt_q == 4'd8)) begin
            mem_we                 = 1'b1;
            wr_pulse_d             = 1'b1;
            ptr_d[PAGE_BITS-1:0]   = ptr_q[PAGE_BITS-1:0] + PAGE_BITS'(1);
            state_d                = ACK_WDATA;
            sda_oe_d               = 1'b1;
            bit_cnt_d              = '0;
          end
        end
        ACK_WDATA: begin
          if (scl_fall) begin
            state_d  = WDATA;
            sda_oe_d = 1'b0;
          end
        end
        RDATA: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              state_d   = MACK;
              sda_oe_d  = 1'b0;
              bit_cnt_d = '0;
            end else if (bit_cnt_q != 4'd0) begin
              rdata_d  = {rdata_q[6:0], 1'b0};
              sda_oe_d = ~rdata_q[6];
            end
          end
        end
        MACK: begin
          // bit_cnt marks that the master acknowledged, so the next fall starts another byte.
          if (scl_rise) begin
            if (!sda_s) begin
              ptr_d     = ptr_q + ADDR_W'(1);
              bit_cnt_d = 4'd1;
            end else begin
              state_d = IDLE;
            end
          end else if (scl_fall && (bit_cnt_q == 4'd1)) begin
            state_d   = RDATA;
            bit_cnt_d = '0;
            rdata_d   = rd_byte;
            sda_oe_d  = ~rd_byte[7];
          end
        end
        default: begin
          state_d  = IDLE;
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      rdata_q    <= '0;
      ptr_q      <= '0;
      rw_q       <= 1'b0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      wr_pulse_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      rdata_q    <= rdata_d;
      ptr_q      <= ptr_d;
      rw_q       <= rw_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      wr_pulse_q <= wr_pulse_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (mem_we && !RESET) begin
      mem_q[ptr_q] <= shift_q;
    end
  end

  assign SDA      = sda_oe_q ? 1'b0 : 1'bz;
  assign BUSY     = busy_q;
  assign WR_PULSE = wr_pulse_q;

endmodule
